// File: rtl/beta_dmem_arbiter.sv
// beta_dmem_arbiter: round-robin share of one data-memory port
// between LSU write (W), LSU read (R) and fetch (F), with a watchdog.
module beta_dmem_arbiter #(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      w_req_i,
  input  logic [AddressWidth-1:0]   w_addr_i,
  input  logic [DataWidth/8-1:0]    w_strb_i,
  input  logic [DataWidth-1:0]      w_data_i,
  output logic                      w_ready_o,
  output logic                      w_valid_o,
  input  logic                      r_req_i,
  input  logic [AddressWidth-1:0]   r_addr_i,
  input  logic [DataWidth/8-1:0]    r_strb_i,
  output logic                      r_ready_o,
  output logic                      r_valid_o,
  input  logic                      f_req_i,
  input  logic [AddressWidth-1:0]   f_addr_i,
  output logic                      f_ready_o,
  output logic                      f_valid_o,
  output logic [DataWidth-1:0]      rdata_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [AddressWidth-1:0]   mem_addr_o,
  output logic [DataWidth/8-1:0]    mem_strb_o,
  output logic [DataWidth-1:0]      mem_wdata_o,
  input  logic                      mem_ready_i,
  input  logic                      mem_valid_i,
  input  logic [DataWidth-1:0]      mem_rdata_i,
  output logic                      timeout_o
);

  localparam int SW = DataWidth / 8;
  localparam int CW = $clog2(TimeoutCycles + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] P_W = 2'd0;
  localparam logic [1:0] P_R = 2'd1;
  localparam logic [1:0] P_F = 2'd2;

  logic [1:0]              state;
  logic [1:0]              grant;
  logic [1:0]              rr_ptr;
  logic [1:0]              win;
  logic                    win_vld;
  logic [CW-1:0]           cnt;
  logic                    sel_we;
  logic [AddressWidth-1:0] sel_addr;
  logic [SW-1:0]           sel_strb;
  logic [DataWidth-1:0]    sel_wdata;
  logic                    in_req;
  logic                    in_resp;
  logic                    expire;
  logic                    done;
  logic                    is_w;
  logic                    is_r;
  logic                    is_f;

  // Pick the first requester after the last winner, cyclic W->R->F
  always_comb begin
    win     = P_W;
    win_vld = w_req_i | r_req_i | f_req_i;
    case (rr_ptr)
      P_W: begin
        if (r_req_i)      win = P_R;
        else if (f_req_i) win = P_F;
        else              win = P_W;
      end
      P_R: begin
        if (f_req_i)      win = P_F;
        else if (w_req_i) win = P_W;
        else              win = P_R;
      end
      default: begin
        if (w_req_i)      win = P_W;
        else if (r_req_i) win = P_R;
        else              win = P_F;
      end
    endcase
  end

  // Memory request fields of the prospective winner
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = f_addr_i;
    sel_strb  = '1;
    sel_wdata = '0;
    case (win)
      P_W: begin
        sel_we    = 1'b1;
        sel_addr  = w_addr_i;
        sel_strb  = w_strb_i;
        sel_wdata = w_data_i;
      end
      P_R: begin
        sel_addr = r_addr_i;
        sel_strb = r_strb_i;
      end
      default: ;
    endcase
  end

  // Transaction FSM, grant pointer and response watchdog
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      grant       <= P_W;
      rr_ptr      <= P_F;
      cnt         <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_strb_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            grant       <= win;
            rr_ptr      <= win;
            mem_req_o   <= 1'b1;
            mem_we_o    <= sel_we;
            mem_addr_o  <= sel_addr;
            mem_strb_o  <= sel_strb;
            mem_wdata_o <= sel_wdata;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready_i) begin
            mem_req_o <= 1'b0;
            cnt       <= '0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (mem_valid_i || expire) state <= S_IDLE;
          else                       cnt   <= cnt + CW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_req  = (state == S_REQ);
  assign in_resp = (state == S_RESP);
  assign expire  = (cnt == CW'(TimeoutCycles));
  assign done    = in_resp & (mem_valid_i | expire);
  assign is_w    = (grant == P_W);
  assign is_r    = (grant == P_R);
  assign is_f    = (grant == P_F);

  assign w_ready_o = in_req & mem_ready_i & is_w;
  assign r_ready_o = in_req & mem_ready_i & is_r;
  assign f_ready_o = in_req & mem_ready_i & is_f;
  assign w_valid_o = done & is_w;
  assign r_valid_o = done & is_r;
  assign f_valid_o = done & is_f;
  assign timeout_o = in_resp & expire & ~mem_valid_i;
  assign rdata_o   = (in_resp & mem_valid_i & ~is_w)
                   ? mem_rdata_i : '0;

endmodule

// File: tb/tb_beta_dmem_arbiter.sv
// tb_beta_dmem_arbiter: vector table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_beta_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int T  = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          w_req_i, r_req_i, f_req_i;
  logic [AW-1:0] w_addr_i, r_addr_i, f_addr_i;
  logic [3:0]    w_strb_i, r_strb_i;
  logic [DW-1:0] w_data_i;
  logic          w_ready_o, w_valid_o, r_ready_o, r_valid_o;
  logic          f_ready_o, f_valid_o, timeout_o;
  logic [DW-1:0] rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_strb_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ready_i, mem_valid_i;
  logic [DW-1:0] mem_rdata_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  beta_dmem_arbiter #(
    .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(T)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .w_req_i(w_req_i), .w_addr_i(w_addr_i),
    .w_strb_i(w_strb_i), .w_data_i(w_data_i),
    .w_ready_o(w_ready_o), .w_valid_o(w_valid_o),
    .r_req_i(r_req_i), .r_addr_i(r_addr_i),
    .r_strb_i(r_strb_i),
    .r_ready_o(r_ready_o), .r_valid_o(r_valid_o),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i),
    .f_ready_o(f_ready_o), .f_valid_o(f_valid_o),
    .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_strb_o(mem_strb_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_valid_i(mem_valid_i),
    .mem_rdata_i(mem_rdata_i),
    .timeout_o(timeout_o)
  );

  // [7]mem_req [6]w_rdy [5]w_vld [4]r_rdy [3]r_vld
  // [2]f_rdy [1]f_vld [0]timeout
  function automatic logic [7:0] flags();
    return {mem_req_o, w_ready_o, w_valid_o, r_ready_o,
            r_valid_o, f_ready_o, f_valid_o, timeout_o};
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_fields(string nm, int p,
                            logic [31:0] a, logic [3:0] s,
                            logic [31:0] d);
    chk({nm, " we"}, 32'(mem_we_o), 32'(p == 0));
    chk({nm, " addr"}, mem_addr_o, a);
    chk({nm, " strb"}, 32'(mem_strb_o), 32'(s));
    if (p == 0) chk({nm, " wdata"}, mem_wdata_o, d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    w_req_i = 0; r_req_i = 0; f_req_i = 0;
    mem_ready_i = 0; mem_valid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    clr_in();
    rst_i = 1;
    tick();
    rst_i = 0;
  endtask

  typedef struct {
    bit          rs;
    bit          w, r, f;
    bit          rdy, vld;
    logic [31:0] rd;
    logic [7:0]  ef;
    logic [31:0] erd;
    int          port;
  } vec_t;

  function automatic vec_t mk(bit rs, bit w, bit r, bit f,
                              bit rdy, bit vld,
                              logic [31:0] rd, logic [7:0] ef,
                              logic [31:0] erd, int port);
    vec_t v;
    v.rs = rs; v.w = w; v.r = r; v.f = f;
    v.rdy = rdy; v.vld = vld; v.rd = rd;
    v.ef = ef; v.erd = erd; v.port = port;
    return v;
  endfunction

  function automatic logic [31:0] fix_addr(int p);
    return (p == 0) ? 32'h200 : (p == 1) ? 32'h100 : 32'h300;
  endfunction

  vec_t tv[$];

  initial begin
    bit          pend[3];
    logic [31:0] ra[3];
    logic [31:0] rd[3];
    logic [3:0]  rs[3];
    int          skip[3];
    int          ph, own, last, rcnt, dly, rwait;
    logic [7:0]  ef;
    logic [31:0] erd;

    rst_i = 1;
    clr_in();
    w_addr_i = 32'h200; w_strb_i = 4'h3; w_data_i = 32'hCAFE0001;
    r_addr_i = 32'h100; r_strb_i = 4'hF;
    f_addr_i = 32'h300;

    // lone R read
    tv.push_back(mk(1,0,0,0,0,0,0,8'h00,0,0));
    tv.push_back(mk(0,0,1,0,0,0,0,8'h00,0,0));
    tv.push_back(mk(0,0,1,0,0,0,0,8'h80,0,1));
    tv.push_back(mk(0,0,1,0,0,0,0,8'h80,0,1));
    tv.push_back(mk(0,0,1,0,1,0,0,8'h90,0,1));
    tv.push_back(mk(0,0,0,0,0,1,32'hDEADBEEF,8'h08,
                    32'hDEADBEEF,0));
    tv.push_back(mk(0,0,0,0,0,0,0,8'h00,0,0));
    // W,R,F together from reset
    tv.push_back(mk(1,0,0,0,0,0,0,8'h00,0,0));
    tv.push_back(mk(0,1,1,1,0,0,0,8'h00,0,0));
    tv.push_back(mk(0,1,1,1,1,0,0,8'hC0,0,0));
    tv.push_back(mk(0,0,1,1,0,1,32'h99999999,8'h20,0,0));
    tv.push_back(mk(0,0,1,1,0,0,0,8'h00,0,0));
    tv.push_back(mk(0,0,1,1,1,0,0,8'h90,0,1));
    tv.push_back(mk(0,0,0,1,0,1,32'h11223344,8'h08,
                    32'h11223344,0));
    tv.push_back(mk(0,0,0,1,0,0,0,8'h00,0,0));
    tv.push_back(mk(0,0,0,1,1,0,0,8'h84,0,2));
    tv.push_back(mk(0,0,0,0,0,1,32'h55667788,8'h02,
                    32'h55667788,0));
    tv.push_back(mk(0,0,0,0,1,1,32'hAAAAAAAA,8'h00,0,0));
    tv.push_back(mk(0,0,0,0,0,0,0,8'h00,0,0));

    tick();
    foreach (tv[i]) begin
      rst_i = tv[i].rs;
      w_req_i = tv[i].w; r_req_i = tv[i].r; f_req_i = tv[i].f;
      mem_ready_i = tv[i].rdy; mem_valid_i = tv[i].vld;
      mem_rdata_i = tv[i].rd;
      @(negedge clk);
      if (!tv[i].rs) begin
        chk($sformatf("vec%0d flags", i), 32'(flags()),
            32'(tv[i].ef));
        chk($sformatf("vec%0d rdata", i), rdata_o, tv[i].erd);
        if (tv[i].ef[7])
          chk_fields($sformatf("vec%0d", i), tv[i].port,
                     fix_addr(tv[i].port),
                     (tv[i].port == 0) ? 4'h3 : 4'hF,
                     32'hCAFE0001);
      end
      tick();
    end
    rst_i = 0;

    // watchdog expiry on a fetch, then a late response
    do_reset();
    f_req_i = 1;
    tick();
    mem_ready_i = 1;
    @(negedge clk);
    chk("to accept", 32'(flags()), 32'h84);
    tick();
    f_req_i = 0; mem_ready_i = 0; mem_rdata_i = 32'h12345678;
    for (int k = 0; k <= T; k++) begin
      @(negedge clk);
      chk($sformatf("to resp%0d", k), 32'(flags()),
          (k == T) ? 32'h03 : 32'h00);
      chk($sformatf("to rdata%0d", k), rdata_o, 32'h0);
      tick();
    end
    mem_valid_i = 1;
    @(negedge clk);
    chk("late valid", 32'(flags()), 32'h00);
    chk("late rdata", rdata_o, 32'h0);
    tick();
    mem_valid_i = 0;

    // response arriving exactly at expiry counts as normal
    f_req_i = 1;
    tick();
    mem_ready_i = 1;
    tick();
    f_req_i = 0; mem_ready_i = 0;
    for (int k = 0; k <= T; k++) begin
      mem_valid_i = (k == T);
      mem_rdata_i = 32'hABCD0123;
      @(negedge clk);
      chk($sformatf("edge resp%0d", k), 32'(flags()),
          (k == T) ? 32'h02 : 32'h00);
      tick();
    end
    mem_valid_i = 0;
    @(negedge clk);
    chk("edge idle", 32'(flags()), 32'h00);

    // reset during the response phase of a store
    do_reset();
    w_req_i = 1;
    tick();
    mem_ready_i = 1;
    tick();
    w_req_i = 0; mem_ready_i = 0;
    @(negedge clk);
    chk("rst resp wait", 32'(flags()), 32'h00);
    rst_i = 1;
    tick();
    rst_i = 0; mem_valid_i = 1; mem_rdata_i = 32'h77777777;
    @(negedge clk);
    chk("rst flags", 32'(flags()), 32'h00);
    chk("rst rdata", rdata_o, 32'h0);
    chk("rst we", 32'(mem_we_o), 32'h0);
    chk("rst addr", mem_addr_o, 32'h0);
    chk("rst strb", 32'(mem_strb_o), 32'h0);
    chk("rst wdata", mem_wdata_o, 32'h0);
    tick();
    mem_valid_i = 0; w_req_i = 1; r_req_i = 1;
    tick();
    @(negedge clk);
    chk("rst regrant", 32'(flags()), 32'h80);
    chk_fields("rst regrant", 0, 32'h200, 4'h3, 32'hCAFE0001);

    // randomized traffic against the transaction model
    do_reset();
    ph = 0; own = 0; last = 2; rcnt = 0; dly = 0; rwait = 0;
    for (int p = 0; p < 3; p++) begin
      pend[p] = 0; skip[p] = 0;
    end
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < 3; p++) begin
        if (!pend[p] && $urandom_range(2) == 0) begin
          pend[p] = 1;
          ra[p] = $urandom;
          rd[p] = $urandom;
          rs[p] = 4'($urandom);
          skip[p] = 0;
        end
      end
      w_req_i = pend[0]; w_addr_i = ra[0];
      w_strb_i = rs[0]; w_data_i = rd[0];
      r_req_i = pend[1]; r_addr_i = ra[1]; r_strb_i = rs[1];
      f_req_i = pend[2]; f_addr_i = ra[2];
      mem_rdata_i = $urandom;
      mem_ready_i = 0; mem_valid_i = 0;
      if (ph == 0) begin
        mem_ready_i = ($urandom_range(3) == 0);
        mem_valid_i = ($urandom_range(3) == 0);
      end else if (ph == 1) begin
        mem_ready_i = (rwait == 0);
        mem_valid_i = ($urandom_range(3) == 0);
      end else begin
        mem_ready_i = ($urandom_range(3) == 0);
        mem_valid_i = (rcnt == dly);
      end

      ef = 8'h00;
      erd = '0;
      if (ph == 1) begin
        ef[7] = 1'b1;
        if (mem_ready_i) ef = ef | (8'h40 >> (2 * own));
      end else if (ph == 2) begin
        if (mem_valid_i) begin
          ef = ef | (8'h20 >> (2 * own));
          if (own != 0) erd = mem_rdata_i;
        end else if (rcnt == T) begin
          ef = ef | (8'h20 >> (2 * own)) | 8'h01;
        end
      end

      @(negedge clk);
      chk($sformatf("rnd%0d flags", c), 32'(flags()), 32'(ef));
      chk($sformatf("rnd%0d rdata", c), rdata_o, erd);
      if (ph == 1)
        chk_fields($sformatf("rnd%0d", c), own, ra[own],
                   (own == 2) ? 4'hF : rs[own], rd[own]);

      if (ph == 0) begin
        if (pend[0] || pend[1] || pend[2]) begin
          for (int k = 3; k >= 1; k--)
            if (pend[(last + k) % 3]) own = (last + k) % 3;
          for (int q = 0; q < 3; q++) begin
            if (q != own && pend[q]) begin
              skip[q]++;
              chk($sformatf("rnd%0d fair%0d", c, q),
                  32'(skip[q] <= 2), 32'h1);
            end
          end
          skip[own] = 0;
          last = own;
          ph = 1;
          rwait = $urandom_range(3);
        end
      end else if (ph == 1) begin
        if (mem_ready_i) begin
          ph = 2;
          rcnt = 0;
          pend[own] = 0;
          dly = $urandom_range(6);
        end else begin
          rwait--;
        end
      end else begin
        if (mem_valid_i || rcnt == T) ph = 0;
        else rcnt++;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
